// File: rtl/axi_burst_ram_slave.sv
// AXI4 burst slave backed by a word-addressed RAM with byte strobes.
// Independent write and read engines, one outstanding burst each, FIXED/INCR only.
module axi_burst_ram_slave #(
    parameter int ID_WIDTH  = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [31:0]         r_mem [MEM_WORDS];
    logic                r_live;

    logic [1:0]          r_wState;
    logic [ID_WIDTH-1:0] r_bid;
    logic [AW-1:0]       r_wIdx;
    logic [7:0]          r_wLen;
    logic [7:0]          r_wCnt;
    logic [1:0]          r_wBurst;
    logic                r_wErr;
    logic                r_bvalid;
    logic [1:0]          r_bresp;

    logic [0:0]          r_rState;
    logic [ID_WIDTH-1:0] r_rid;
    logic [AW-1:0]       r_rIdx;
    logic [7:0]          r_rLen;
    logic [7:0]          r_rCnt;
    logic [1:0]          r_rBurst;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;

    logic                w_awHs;
    logic                w_wHs;
    logic                w_wFinal;
    logic                w_lastErr;
    logic                w_wUnsup;
    logic                w_arHs;
    logic                w_rHs;
    logic                w_arUnsup;
    logic                w_rUnsup;
    logic [AW-1:0]       w_arIdx;
    logic [AW-1:0]       w_rNextIdx;
    logic                w_unused;

    assign w_unused = &{1'b0, s_axi_awaddr[31:AW+2], s_axi_awaddr[1:0],
                        s_axi_araddr[31:AW+2], s_axi_araddr[1:0]};

    // Ready flags stay low until the first clock edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    assign s_axi_awready = r_live && (r_wState == W_IDLE);
    assign s_axi_wready  = (r_wState == W_DATA);
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;

    assign w_awHs    = s_axi_awready && s_axi_awvalid;
    assign w_wHs     = s_axi_wready && s_axi_wvalid;
    assign w_wFinal  = (r_wCnt == r_wLen);
    assign w_lastErr = (s_axi_wlast != w_wFinal);
    assign w_wUnsup  = r_wBurst[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wState <= W_IDLE;
            r_bid    <= '0;
            r_wIdx   <= '0;
            r_wLen   <= '0;
            r_wCnt   <= '0;
            r_wBurst <= '0;
            r_wErr   <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= '0;
        end else begin
            case (r_wState)
                W_IDLE: if (w_awHs) begin
                    r_bid    <= s_axi_awid;
                    r_wIdx   <= s_axi_awaddr[AW+1:2];
                    r_wLen   <= s_axi_awlen;
                    r_wBurst <= s_axi_awburst;
                    r_wCnt   <= '0;
                    r_wErr   <= 1'b0;
                    r_wState <= W_DATA;
                end
                W_DATA: if (w_wHs) begin
                    r_wIdx <= (r_wBurst == 2'b01) ? r_wIdx + AW'(1) : r_wIdx;
                    r_wCnt <= r_wCnt + 8'd1;
                    r_wErr <= r_wErr | w_lastErr;
                    if (w_wFinal) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= (w_wUnsup || r_wErr || w_lastErr) ? 2'b10 : 2'b00;
                        r_wState <= W_RESP;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    r_bvalid <= 1'b0;
                    r_bresp  <= '0;
                    r_wState <= W_IDLE;
                end
                default: r_wState <= W_IDLE;
            endcase
        end
    end

    // Unsupported bursts still consume their beats but never touch the array.
    always_ff @(posedge aclk) begin
        if (w_wHs && !w_wUnsup) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_wIdx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_arready = r_live && (r_rState == R_IDLE);
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;

    assign w_arHs     = s_axi_arready && s_axi_arvalid;
    assign w_rHs      = r_rvalid && s_axi_rready;
    assign w_arUnsup  = s_axi_arburst[1];
    assign w_rUnsup   = r_rBurst[1];
    assign w_arIdx    = s_axi_araddr[AW+1:2];
    assign w_rNextIdx = (r_rBurst == 2'b01) ? r_rIdx + AW'(1) : r_rIdx;

    // Each beat is fetched into the output register one edge ahead of its use.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rState <= R_IDLE;
            r_rid    <= '0;
            r_rIdx   <= '0;
            r_rLen   <= '0;
            r_rCnt   <= '0;
            r_rBurst <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            case (r_rState)
                R_IDLE: if (w_arHs) begin
                    r_rid    <= s_axi_arid;
                    r_rIdx   <= w_arIdx;
                    r_rLen   <= s_axi_arlen;
                    r_rBurst <= s_axi_arburst;
                    r_rCnt   <= '0;
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_arUnsup ? 32'd0 : r_mem[w_arIdx];
                    r_rresp  <= w_arUnsup ? 2'b10 : 2'b00;
                    r_rlast  <= (s_axi_arlen == 8'd0);
                    r_rState <= R_DATA;
                end
                R_DATA: if (w_rHs) begin
                    if (r_rlast) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_rState <= R_IDLE;
                    end else begin
                        r_rIdx  <= w_rNextIdx;
                        r_rCnt  <= r_rCnt + 8'd1;
                        r_rdata <= w_rUnsup ? 32'd0 : r_mem[w_rNextIdx];
                        r_rlast <= ((r_rCnt + 8'd1) == r_rLen);
                    end
                end
                default: r_rState <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Scoreboard bench for axi_burst_ram_slave: a reference memory model predicts
// every B and R beat, and channel monitors compare them as the DUT presents them.
module tb_axi_burst_ram_slave;
    localparam int IDW   = 4;
    localparam int WORDS = 1024;
    localparam int AWB   = $clog2(WORDS);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
        logic [1:0]     resp;
        logic           last;
    } rbeat_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } bexp_t;

    logic           aclk;
    logic           aresetn;
    logic [IDW-1:0] s_axi_awid;
    logic [31:0]    s_axi_awaddr;
    logic [7:0]     s_axi_awlen;
    logic [1:0]     s_axi_awburst;
    logic           s_axi_awvalid;
    logic           s_axi_awready;
    logic [31:0]    s_axi_wdata;
    logic [3:0]     s_axi_wstrb;
    logic           s_axi_wlast;
    logic           s_axi_wvalid;
    logic           s_axi_wready;
    logic [IDW-1:0] s_axi_bid;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready;
    logic [IDW-1:0] s_axi_arid;
    logic [31:0]    s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic [1:0]     s_axi_arburst;
    logic           s_axi_arvalid;
    logic           s_axi_arready;
    logic [IDW-1:0] s_axi_rid;
    logic [31:0]    s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic           s_axi_rvalid;
    logic           s_axi_rready;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] wdq[$];
    logic [3:0]  wsq[$];
    logic [31:0] memModel [WORDS];
    int          total = 0;
    int          bad   = 0;
    bit          rBeatOpen = 0;

    axi_burst_ram_slave #(.ID_WIDTH(IDW), .MEM_WORDS(WORDS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // R monitor: the beat on the bus must always be the scoreboard head, held until taken.
    always @(negedge aclk) begin
        #2;
        if (aresetn !== 1'b1) begin
            rBeatOpen = 0;
        end else begin
            if (rBeatOpen) begin
                total++;
                if (s_axi_rvalid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL no_bubble: rvalid=%b required 1", s_axi_rvalid);
                end
            end
            rBeatOpen = 0;
            if (s_axi_rvalid === 1'b1) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_rbeat: rvalid=1 data=%h, required no beat", s_axi_rdata);
                end else begin
                    if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== rq[0]) begin
                        bad++;
                        $display("[TB] FAIL rbeat: got id=%0h data=%h resp=%b last=%b, required id=%0h data=%h resp=%b last=%b",
                                 s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
                                 rq[0].id, rq[0].data, rq[0].resp, rq[0].last);
                    end
                    if (s_axi_rready === 1'b1) begin
                        rBeatOpen = !rq[0].last;
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge aclk) begin
        #2;
        if (aresetn === 1'b1 && s_axi_bvalid === 1'b1) begin
            total++;
            if (bq.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_b: bvalid=1 bresp=%b, required no response", s_axi_bresp);
            end else begin
                if ({s_axi_bid, s_axi_bresp} !== bq[0]) begin
                    bad++;
                    $display("[TB] FAIL bresp: got id=%0h resp=%b, required id=%0h resp=%b",
                             s_axi_bid, s_axi_bresp, bq[0].id, bq[0].resp);
                end
                if (s_axi_bready === 1'b1) void'(bq.pop_front());
            end
        end
    end

    // Drives one write burst from wdq/wsq; wlastAt is the beat carrying wlast (-1 for none).
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [IDW-1:0] id, input int wlastAt);
        logic [AWB-1:0] idx;
        logic           mismatch;
        int             cnt;
        idx      = addr[AWB+1:2];
        mismatch = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ((i == wlastAt) != (i == int'(len))) mismatch = 1'b1;
            if (!burst[1]) begin
                for (int b = 0; b < 4; b++)
                    if (wsq[i][b]) memModel[idx][8*b +: 8] = wdq[i][8*b +: 8];
            end
            if (burst == 2'b01) idx = idx + 1'b1;
        end
        bq.push_back({id, (burst[1] || mismatch) ? 2'b10 : 2'b00});

        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        cnt = 0;
        while (s_axi_awready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        if (cnt >= 50) begin
            total++; bad++;
            $display("[TB] FAIL aw_timeout: awready=%b, required 1", s_axi_awready);
        end
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = wdq[i]; s_axi_wstrb = wsq[i]; s_axi_wlast = (i == wlastAt);
            s_axi_wvalid = 1'b1;
            cnt = 0;
            while (s_axi_wready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
            if (cnt >= 50) begin
                total++; bad++;
                $display("[TB] FAIL w_timeout: wready=%b at beat %0d, required 1", s_axi_wready, i);
            end
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        cnt = 0;
        while (bq.size() != 0 && cnt < 50) begin
            s_axi_bready = (cnt >= 2);
            @(negedge aclk);
            cnt++;
        end
        s_axi_bready = 1'b0;
        if (cnt >= 50) begin
            total++; bad++;
            $display("[TB] FAIL b_timeout: %0d responses outstanding, required 0", bq.size());
            bq.delete();
        end
    endtask

    // Issues one read burst; pat gives rready per cycle (bit cycle%4).
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [IDW-1:0] id, input logic [3:0] pat);
        logic [AWB-1:0] idx;
        int             cnt;
        idx = addr[AWB+1:2];
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back({id, burst[1] ? 32'd0 : memModel[idx], burst[1] ? 2'b10 : 2'b00, i == int'(len)});
            if (burst == 2'b01) idx = idx + 1'b1;
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        cnt = 0;
        while (s_axi_arready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        total++;
        if (cnt >= 50 || s_axi_rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ar_accept: arready=%b rvalid=%b, required arready=1 rvalid=0", s_axi_arready, s_axi_rvalid);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        total++;
        if (s_axi_rvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL first_rvalid_latency: rvalid=%b, required 1", s_axi_rvalid);
        end
        cnt = 0;
        s_axi_rready = pat[0];
        while (rq.size() != 0 && cnt < 200) begin
            @(negedge aclk);
            cnt++;
            s_axi_rready = pat[cnt % 4];
        end
        s_axi_rready = 1'b0;
        if (cnt >= 200) begin
            total++; bad++;
            $display("[TB] FAIL r_timeout: %0d beats outstanding, required 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata} !== 50'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: awr=%b wr=%b bv=%b arr=%b rv=%b rl=%b br=%b rr=%b bid=%h rid=%h rdata=%h, required all 0",
                     s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
                     s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata);
        end
        aresetn = 1'b1;
        #1;
        total++;
        if ({s_axi_awready, s_axi_arready} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL ready_before_edge: aw/ar=%b, required 00", {s_axi_awready, s_axi_arready});
        end
        @(negedge aclk);
        total++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL ready_after_release: aw/ar=%b, required 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_basic_burst();
        wdq = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};
        wsq = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h200, 8'd3, 2'b01, 4'h0, 3);
        total++;
        if (s_axi_awready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL awready_after_b: awready=%b, required 1", s_axi_awready);
        end
        axi_read(32'h200, 8'd3, 2'b01, 4'h0, 4'b1111);
    endtask

    task automatic test_strobes();
        wdq = '{32'h11223344}; wsq = '{4'hF};
        axi_write(32'h300, 8'd0, 2'b01, 4'h3, 0);
        wdq = '{32'hAABBCCDD}; wsq = '{4'b0101};
        axi_write(32'h300, 8'd0, 2'b01, 4'h5, 0);
        axi_read(32'h300, 8'd0, 2'b01, 4'h6, 4'b1111);
    endtask

    task automatic test_rready_stall();
        axi_read(32'h200, 8'd3, 2'b01, 4'h9, 4'b1001);
    endtask

    task automatic test_wrap_fixed();
        wdq = '{32'hA0A0A0A1, 32'hB0B0B0B2}; wsq = '{4'hF, 4'hF};
        axi_write(32'h4 * (WORDS - 1), 8'd1, 2'b01, 4'h1, 1);
        axi_read(32'h4 * (WORDS - 1), 8'd1, 2'b01, 4'h2, 4'b1111);
        axi_read(32'h0, 8'd0, 2'b01, 4'h2, 4'b1111);
        wdq = '{32'h55555555}; wsq = '{4'hF};
        axi_write(32'h404, 8'd0, 2'b01, 4'h7, 0);
        wdq = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        wsq = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h400, 8'd3, 2'b00, 4'h8, 3);
        axi_read(32'h400, 8'd1, 2'b01, 4'h8, 4'b1111);
    endtask

    task automatic test_errors();
        wdq = '{32'hFFFFFFFF}; wsq = '{4'hF};
        axi_write(32'h300, 8'd0, 2'b10, 4'hB, 0);
        axi_read(32'h300, 8'd0, 2'b01, 4'hB, 4'b1111);
        wdq = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        wsq = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h500, 8'd3, 2'b01, 4'hC, 1);
        axi_read(32'h500, 8'd3, 2'b01, 4'hC, 4'b1111);
        wdq = '{32'h0A0A0A0A, 32'h0B0B0B0B}; wsq = '{4'hF, 4'b0011};
        axi_write(32'h600, 8'd1, 2'b01, 4'hD, -1);
        axi_read(32'h600, 8'd1, 2'b01, 4'hD, 4'b1111);
        axi_read(32'h200, 8'd2, 2'b11, 4'hE, 4'b1111);
    endtask

    task automatic test_back_to_back();
        axi_read(32'h200, 8'd1, 2'b00, 4'h4, 4'b1111);
        axi_read(32'h204, 8'd2, 2'b01, 4'h5, 4'b1111);
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        rq.push_back({4'h1, memModel[10'h080], 2'b00, 1'b0});
        rq.push_back({4'h1, memModel[10'h081], 2'b00, 1'b0});
        s_axi_arid = 4'h1; s_axi_araddr = 32'h200; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1;
        cnt = 0;
        while (s_axi_arready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        if (cnt >= 50) begin
            total++; bad++;
            $display("[TB] FAIL ar_timeout: arready=%b, required 1", s_axi_arready);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(negedge aclk);
        s_axi_rready = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        total++;
        if ({s_axi_rvalid, s_axi_rlast, s_axi_arready} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL async_reset: rvalid/rlast/arready=%b, required 000",
                     {s_axi_rvalid, s_axi_rlast, s_axi_arready});
        end
        total++;
        if (rq.size() != 1) begin
            bad++;
            $display("[TB] FAIL beats_before_reset: %0d left, required 1", rq.size());
        end
        rq.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if (s_axi_arready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arready_at_release: arready=%b, required 0", s_axi_arready);
        end
        @(negedge aclk);
        total++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arready_after_release: arready=%b rvalid=%b, required 1 0", s_axi_arready, s_axi_rvalid);
        end
        axi_read(32'h300, 8'd0, 2'b01, 4'h2, 4'b1111);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < WORDS; i++) memModel[i] = '0;

        test_reset();
        test_basic_burst();
        test_strobes();
        test_rready_stall();
        test_wrap_fixed();
        test_errors();
        test_back_to_back();
        test_reset_mid_read();

        repeat (3) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
